// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared state encoding and default sizing for the dmem_pipe block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int DEF_N = 16;
    localparam int DEF_R = 6;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module : dmem_array
// Brief  : 2**R x N word storage, one byte-masked write port, one async read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int R = DEF_R
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [R-1:0]     widx_i,
    input  logic [N-1:0]     wdata_i,
    input  logic [N/8-1:0]   wbe_i,
    input  logic [R-1:0]     ridx_i,
    output logic [N-1:0]     rdata_o
);

    logic [N-1:0] mem_q [0:(1<<R)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < N/8; i++) begin
                if (wbe_i[i]) begin
                    mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous read lets a read issued right after a write see new data.
    assign rdata_o = mem_q[ridx_i];

endmodule

`default_nettype wire

// File: rtl/dmem_pipe.sv
// ============================================================================
// Module : dmem_pipe
// Brief  : Self-clearing data memory with valid/ready requests and 1-cycle
//          registered read / error responses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int R = DEF_R
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [N-1:0]     addr,
    input  logic [N-1:0]     writedata,
    input  logic [N/8-1:0]   byte_en,
    output logic             resp_valid,
    output logic [N-1:0]     readdata,
    output logic             addr_err,
    output logic             init_done
);

    state_t          state_q;
    logic [R-1:0]    cnt_q;
    logic            resp_valid_q, resp_valid_d;
    logic            addr_err_q,   addr_err_d;
    logic [N-1:0]    readdata_q,   readdata_d;

    logic            accept;
    logic            in_range;
    logic            mem_we;
    logic [R-1:0]    mem_widx;
    logic [N-1:0]    mem_wdata;
    logic [N/8-1:0]  mem_wbe;
    logic [N-1:0]    mem_rdata;

    assign accept   = req_valid && (state_q == S_READY);
    assign in_range = (addr[N-1:R] == '0);

    // During clear the write port is owned by the counter; afterwards by requests.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = addr[R-1:0];
        mem_wdata = writedata;
        mem_wbe   = byte_en;
        if (state_q == S_INIT) begin
            mem_we    = !rst;
            mem_widx  = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (accept && req_write && in_range) begin
            mem_we    = !rst;
        end
    end

    always_comb begin
        resp_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        readdata_d   = readdata_q;
        if (accept) begin
            if (!in_range) begin
                resp_valid_d = 1'b1;
                addr_err_d   = 1'b1;
                if (!req_write) begin
                    readdata_d = '0;
                end
            end else if (!req_write) begin
                resp_valid_d = 1'b1;
                readdata_d   = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            readdata_q   <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            addr_err_q   <= addr_err_d;
            readdata_q   <= readdata_d;
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + R'(1);
                    if (cnt_q == '1) begin
                        state_q <= S_READY;
                    end
                end
                S_READY: state_q <= S_READY;
                default: state_q <= S_INIT;
            endcase
        end
    end

    dmem_array #(
        .N (N),
        .R (R)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .widx_i  (mem_widx),
        .wdata_i (mem_wdata),
        .wbe_i   (mem_wbe),
        .ridx_i  (addr[R-1:0]),
        .rdata_o (mem_rdata)
    );

    assign req_ready  = (state_q == S_READY);
    assign init_done  = (state_q == S_READY);
    assign resp_valid = resp_valid_q;
    assign addr_err   = addr_err_q;
    assign readdata   = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_pipe.sv
// ============================================================================
// Module : tb_dmem_pipe
// Brief  : Directed bench for dmem_pipe with a word-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_pipe;

    localparam int N     = 16;
    localparam int R     = 6;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [N-1:0]   addr;
    logic [N-1:0]   writedata;
    logic [N/8-1:0] byte_en;
    logic           resp_valid;
    logic [N-1:0]   readdata;
    logic           addr_err;
    logic           init_done;

    int errors = 0;
    int checks = 0;

    dmem_pipe #(.N(N), .R(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .addr       (addr),
        .writedata  (writedata),
        .byte_en    (byte_en),
        .resp_valid (resp_valid),
        .readdata   (readdata),
        .addr_err   (addr_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Reference model: cycles since reset release, word array, last response.
    logic [N-1:0] m_mem [DEPTH];
    int           m_cnt     = 0;
    logic         m_rv      = 1'b0;
    logic         m_err     = 1'b0;
    logic [N-1:0] m_rd      = '0;
    logic         started   = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_cnt = 0;
            m_rv  = 1'b0;
            m_err = 1'b0;
            m_rd  = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            m_rv  = 1'b0;
            m_err = 1'b0;
            if (m_cnt < DEPTH) begin
                m_cnt = m_cnt + 1;
            end else if (req_valid) begin
                if (int'(addr) >= DEPTH) begin
                    m_rv  = 1'b1;
                    m_err = 1'b1;
                    if (!req_write) m_rd = '0;
                end else if (req_write) begin
                    for (int b = 0; b < N/8; b++)
                        if (byte_en[b]) m_mem[addr][8*b +: 8] = writedata[8*b +: 8];
                end else begin
                    m_rv = 1'b1;
                    m_rd = m_mem[addr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready",  N'(req_ready),  N'(m_cnt >= DEPTH));
            chk("init_done",  N'(init_done),  N'(m_cnt >= DEPTH));
            chk("resp_valid", N'(resp_valid), N'(m_rv));
            chk("addr_err",   N'(addr_err),   N'(m_err));
            chk("readdata",   readdata,       m_rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one edge; returns when its response is visible.
    task automatic issue(input logic w, input logic [N-1:0] a, input logic [N-1:0] d,
                         input logic [N/8-1:0] be);
        req_valid = 1'b1;
        req_write = w;
        addr      = a;
        writedata = d;
        byte_en   = be;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            req_valid = 1'b0;
            req_write = 1'($urandom_range(0, 1));
            addr      = N'($urandom_range(0, 127));
            writedata = N'($urandom);
            byte_en   = 2'b11;
            cyc();
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        req_valid = 1'b0;
        while (!init_done && n < 200) begin
            cyc();
            n++;
        end
        chk(name, N'(n), N'(64));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        addr = '0; writedata = '0; byte_en = '0;
        cyc(); cyc(); cyc();
        chk("reset_ready", N'(req_ready), N'(0));
        rst = 1'b0;
        wait_init("init_cycles");
        chk("ready_with_init_done", N'(req_ready), N'(1));

        issue(1'b0, 16'h0005, 16'h0, 2'b00);
        chk("rd5_valid", N'(resp_valid), N'(1));
        chk("rd5_data", readdata, 16'h0000);

        issue(1'b1, 16'h0000, 16'hFFFF, 2'b11);
        issue(1'b0, 16'h0000, 16'h0, 2'b00);
        chk("rd0_valid", N'(resp_valid), N'(1));
        chk("rd0_data", readdata, 16'hFFFF);

        issue(1'b1, 16'h0001, 16'h00FF, 2'b11);
        issue(1'b1, 16'h0001, 16'hAB00, 2'b10);
        issue(1'b0, 16'h0001, 16'h0, 2'b00);
        chk("rd1_merge", readdata, 16'hABFF);

        issue(1'b0, 16'h0040, 16'h0, 2'b00);
        chk("oor_rd_err", N'(addr_err), N'(1));
        chk("oor_rd_data", readdata, 16'h0000);
        issue(1'b1, 16'h0040, 16'h1234, 2'b11);
        chk("oor_wr_err", N'(addr_err), N'(1));
        chk("oor_wr_valid", N'(resp_valid), N'(1));
        issue(1'b0, 16'h0000, 16'h0, 2'b00);
        chk("rd0_after_oor", readdata, 16'hFFFF);

        issue(1'b1, 16'h0002, 16'hBEEF, 2'b00);
        idle(3);
        issue(1'b0, 16'h0000, 16'h0, 2'b00);
        chk("b2b_0", readdata, 16'hFFFF);
        issue(1'b0, 16'h0001, 16'h0, 2'b00);
        chk("b2b_1", readdata, 16'hABFF);
        issue(1'b0, 16'h0002, 16'h0, 2'b00);
        chk("b2b_2", readdata, 16'h0000);

        issue(1'b1, 16'h0007, 16'h1357, 2'b01);
        idle(2);
        chk("retain_after_write", readdata, 16'h0000);
        issue(1'b0, 16'h0007, 16'h0, 2'b00);
        chk("rd7_low_lane", readdata, 16'h0057);
        issue(1'b1, 16'h0080, 16'hFFFF, 2'b11);
        chk("retain_after_errwr", readdata, 16'h0057);
        idle(4);

        // Reset mid-operation, then again partway through the clear.
        issue(1'b1, 16'h0000, 16'h5A5A, 2'b11);
        req_valid = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (20) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        wait_init("reinit_cycles");

        issue(1'b1, 16'h0003, 16'h7777, 2'b11);
        req_valid = 1'b1; req_write = 1'b0; addr = 16'h0003;
        rst = 1'b1; cyc();
        chk("rst_drops_resp", N'(resp_valid), N'(0));
        rst = 1'b0;
        wait_init("reinit2_cycles");
        issue(1'b0, 16'h0000, 16'h0, 2'b00);
        chk("rd0_cleared", readdata, 16'h0000);
        issue(1'b0, 16'h0003, 16'h0, 2'b00);
        chk("rd3_cleared", readdata, 16'h0000);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter N, default 16, data and address width in bits; SHALL be a multiple of 8.
REQ-002 Parameter R, default 6, index bits; depth = 2**R words; SHALL satisfy R < N.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 addr  input  N  word address.
REQ-009 writedata  input  N  write data.
REQ-010 byte_en  input  N/8  per-byte write mask; bit i covers writedata[8i+7:8i].
REQ-011 resp_valid  output  1  one-cycle pulse, read response or error response.
REQ-012 readdata  output  N  read result; holds its value between responses.
REQ-013 addr_err  output  1  one-cycle pulse, coincident with resp_valid, flagging an out-of-range access.
REQ-014 init_done  output  1  high once memory clear has completed.

Function
REQ-015 FSM states: S_INIT and S_READY; rst forces S_INIT with clear counter = 0.
REQ-016 S_INIT: writes 0 to word[counter] each cycle and increments counter; after word 2**R-1 is written, moves to S_READY. Clear takes exactly 2**R cycles.
REQ-017 req_ready = 1 only in S_READY; init_done = 1 only in S_READY.
REQ-018 Request accepted on a rising edge where req_valid & req_ready; no request can be accepted in S_INIT.
REQ-019 Index = addr[R-1:0]; access is out of range when addr[N-1:R] != 0.
REQ-020 Accepted in-range write: updates only the byte lanes selected by byte_en, at the acceptance edge; produces no response.
REQ-021 Write with byte_en = 0: memory unchanged; no response.
REQ-022 Accepted in-range read: resp_valid = 1 and readdata = word[index] in the cycle after acceptance (latency 1).
REQ-023 Out-of-range read: resp_valid = 1, addr_err = 1, readdata = 0, all one cycle after acceptance.
REQ-024 Out-of-range write: memory unchanged; resp_valid = 1 and addr_err = 1 one cycle after acceptance.
REQ-025 Back-to-back requests SHALL be accepted every cycle in S_READY (throughput 1 per cycle).
REQ-026 A read accepted the cycle after a write to the same index SHALL return the post-write data.
REQ-027 readdata retains the last read value after writes, idle cycles and error writes.
REQ-028 Input values while req_valid = 0 SHALL have no effect.

Reset
REQ-029 On rst: req_ready = 0, resp_valid = 0, addr_err = 0, readdata = 0, init_done = 0.
REQ-030 rst asserted mid-init or mid-operation SHALL abort; a pending response is dropped and clearing restarts from word 0.
REQ-031 rst held high for several cycles SHALL keep the block in S_INIT at counter 0; clearing starts on the first edge after rst falls.

Structure
REQ-032 Package dmem_pkg holds the state enum (S_INIT, S_READY) and the default N and R constants.
REQ-033 Sub-module dmem_array holds the storage: one write port with byte-lane mask, one read port, parameters N and R. dmem_pipe holds the FSM, the clear counter, range check and response registers.

Verification
REQ-034 Reset release, defaults -> init_done and req_ready stay 0 for 64 cycles and rise together on cycle 64; then reading index 5 returns 0x0000.
REQ-035 Write 0xFFFF to addr 0x0000 with byte_en = 2'b11, then read addr 0x0000 next cycle -> resp_valid pulses one cycle later with readdata = 0xFFFF.
REQ-036 Write 0x00FF to addr 0x0001 with byte_en = 2'b11, then write 0xAB00 to addr 0x0001 with byte_en = 2'b10, then read addr 0x0001 -> readdata = 0xABFF.
REQ-037 Read addr 0x0040 -> resp_valid = 1, addr_err = 1, readdata = 0x0000. Write 0x1234 to addr 0x0040 -> addr_err pulse; a following read of addr 0x0000 is unchanged.
REQ-038 Reads of addrs 0, 1, 2 issued on consecutive cycles -> three consecutive resp_valid pulses returning 0xFFFF, 0xABFF, 0x0000.
REQ-039 Assert rst at init cycle 20, and again during a read, for 1 cycle each -> no resp_valid appears; init_done rises 64 cycles after rst falls; a prior write to addr 0x0000 now reads 0x0000.
